// File: rtl/mips_run_ctrl_pkg.sv
// Shared definitions for the MIPS run controller: FSM state encoding and small helpers.
package mips_run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    // States in which a start pulse launches a new run.
    function automatic logic accepts_start(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/mips_halt_detect.sv
// Per-core "j ." detector: captures the PC each RUN cycle, counts consecutive repeats,
// and raises a sticky halted flag once the repeat count reaches STALL_LIMIT.
module mips_halt_detect #(
    parameter int PC_W        = 32,
    parameter int STALL_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [PC_W-1:0] pc,
    output logic            halted
);

    localparam int SW = $clog2(STALL_LIMIT + 1);

    logic [PC_W-1:0] prev_pc;
    logic            prev_valid;
    logic [SW-1:0]   stall_cnt;
    logic            repeat_pc;

    // The first enabled cycle after a clear only captures, so it can never count as a repeat.
    assign repeat_pc = prev_valid && (pc == prev_pc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_pc    <= '0;
            prev_valid <= 1'b0;
            stall_cnt  <= '0;
            halted     <= 1'b0;
        end else if (clr) begin
            prev_pc    <= '0;
            prev_valid <= 1'b0;
            stall_cnt  <= '0;
            halted     <= 1'b0;
        end else if (en) begin
            prev_pc    <= pc;
            prev_valid <= 1'b1;
            if (repeat_pc) begin
                if (stall_cnt != SW'(STALL_LIMIT)) begin
                    stall_cnt <= stall_cnt + SW'(1);
                end
                if (stall_cnt == SW'(STALL_LIMIT - 1)) begin
                    halted <= 1'b1;
                end
            end else begin
                stall_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for MIPS cores: sequences core reset, counts RUN cycles, detects the
// all-cores-halted end condition and aborts runaway programs with a watchdog.
module mips_run_ctrl
    import mips_run_ctrl_pkg::*;
#(
    parameter int N_CORES     = 1,
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 4,
    parameter int STALL_LIMIT = 8,
    parameter int MAX_CYCLES  = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N_CORES*PC_W-1:0]   core_pc,
    output logic [N_CORES-1:0]        core_rst_n,
    output logic                      running,
    output logic [N_CORES-1:0]        halted,
    output logic                      done,
    output logic                      timeout,
    output logic [CNT_W-1:0]          cycle_count,
    output state_t                    state
);

    localparam int HW = $clog2(RST_CYCLES + 1);

    state_t               next_state;
    logic                 start_ok;
    logic                 all_halted;
    logic                 wd_expired;
    logic [HW-1:0]        hold_cnt;
    logic [N_CORES-1:0]   core_rst_n_d;
    logic                 running_d;
    logic                 done_d;
    logic                 timeout_d;

    assign start_ok   = start && accepts_start(state);
    assign all_halted = &halted;
    assign wd_expired = (MAX_CYCLES != 0) && (cycle_count == CNT_W'(MAX_CYCLES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start) next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_cnt == '0) next_state = ST_RUN;
            end
            ST_RUN: begin
                // A run that completes on the watchdog's last cycle still counts as done.
                if (all_halted)      next_state = ST_DONE;
                else if (wd_expired) next_state = ST_TIMEOUT;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with the state.
    always_comb begin
        core_rst_n_d = '0;
        running_d    = 1'b0;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
        case (next_state)
            ST_RUN: begin
                core_rst_n_d = '1;
                running_d    = 1'b1;
            end
            ST_DONE: begin
                core_rst_n_d = '1;
                done_d       = 1'b1;
            end
            ST_TIMEOUT: begin
                core_rst_n_d = '1;
                timeout_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_rst_n <= '0;
            running    <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            core_rst_n <= core_rst_n_d;
            running    <= running_d;
            done       <= done_d;
            timeout    <= timeout_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
        end else if (start_ok) begin
            hold_cnt <= HW'(RST_CYCLES - 1);
        end else if (state == ST_HOLD && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count <= '0;
        end else if (start_ok) begin
            cycle_count <= '0;
        end else if (next_state == ST_RUN && cycle_count != {CNT_W{1'b1}}) begin
            cycle_count <= cycle_count + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < N_CORES; i++) begin : g_core
        mips_halt_detect #(
            .PC_W        (PC_W),
            .STALL_LIMIT (STALL_LIMIT)
        ) u_halt_detect (
            .clk    (clk),
            .rst    (rst),
            .clr    (start_ok),
            .en     (state == ST_RUN),
            .pc     (core_pc[i*PC_W +: PC_W]),
            .halted (halted[i])
        );
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: two instances share stimulus, one with a 100-cycle
// watchdog and one with a 29-cycle watchdog that coincides with the halt scenario.
module tb_mips_run_ctrl;
    import mips_run_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] core_pc;

    logic [1:0]  a_core_rst_n, b_core_rst_n;
    logic        a_running, b_running;
    logic [1:0]  a_halted, b_halted;
    logic        a_done, b_done;
    logic        a_timeout, b_timeout;
    logic [31:0] a_cycle_count, b_cycle_count;
    state_t      a_state, b_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_run_ctrl #(
        .N_CORES(2), .PC_W(32), .CNT_W(32), .RST_CYCLES(4), .STALL_LIMIT(8), .MAX_CYCLES(100)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start), .core_pc(core_pc),
        .core_rst_n(a_core_rst_n), .running(a_running), .halted(a_halted), .done(a_done),
        .timeout(a_timeout), .cycle_count(a_cycle_count), .state(a_state)
    );

    mips_run_ctrl #(
        .N_CORES(2), .PC_W(32), .CNT_W(32), .RST_CYCLES(4), .STALL_LIMIT(8), .MAX_CYCLES(29)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start), .core_pc(core_pc),
        .core_rst_n(b_core_rst_n), .running(b_running), .halted(b_halted), .done(b_done),
        .timeout(b_timeout), .cycle_count(b_cycle_count), .state(b_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Called on a negedge while idle/done/timeout; returns on the negedge of RUN cycle 1.
    task automatic do_hold();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int h = 1; h <= 4; h++) begin
            check($sformatf("hold%0d_rst_n_a", h), a_core_rst_n, 2'b00);
            check($sformatf("hold%0d_rst_n_b", h), b_core_rst_n, 2'b00);
            check($sformatf("hold%0d_state", h), a_state, ST_HOLD);
            check($sformatf("hold%0d_status", h),
                  {a_running, a_done, a_timeout, a_halted}, 5'b0);
            check($sformatf("hold%0d_count", h), a_cycle_count, 32'd0);
            tick();
        end
        check("run1_rst_n", a_core_rst_n, 2'b11);
        check("run1_running", a_running, 1'b1);
        check("run1_count_a", a_cycle_count, 32'd1);
        check("run1_count_b", b_cycle_count, 32'd1);
    endtask

    // Core0 spins from cycle 10, core1 from cycle 20; both instances finish done at cycle 30.
    task automatic run_halt(input bit poke_start);
        logic [31:0] p0, p1;
        for (int k = 1; k <= 29; k++) begin
            p0 = (k < 10) ? 32'(k * 4) : 32'd40;
            p1 = (k < 20) ? 32'h1000 + 32'(k * 4) : 32'h1050;
            core_pc = {p1, p0};
            start = (poke_start && k == 5);
            check($sformatf("halt_c%0d_count_a", k), a_cycle_count, 32'(k));
            check($sformatf("halt_c%0d_count_b", k), b_cycle_count, 32'(k));
            check($sformatf("halt_c%0d_running", k), a_running, 1'b1);
            check($sformatf("halt_c%0d_halted_a", k), a_halted, {k >= 29, k >= 19});
            check($sformatf("halt_c%0d_halted_b", k), b_halted, {k >= 29, k >= 19});
            check($sformatf("halt_c%0d_end", k), {a_done, a_timeout, b_done, b_timeout}, 4'b0);
            tick();
        end
        start = 1'b0;
        for (int f = 0; f < 3; f++) begin
            check("halt_done_a", a_done, 1'b1);
            check("halt_done_b", b_done, 1'b1);
            check("halt_timeout_a", a_timeout, 1'b0);
            check("halt_timeout_b", b_timeout, 1'b0);
            check("halt_running", {a_running, b_running}, 2'b00);
            check("halt_count_a", a_cycle_count, 32'd29);
            check("halt_count_b", b_cycle_count, 32'd29);
            check("halt_rst_n", a_core_rst_n, 2'b11);
            check("halt_state", a_state, ST_DONE);
            core_pc = core_pc + 64'h0000_0004_0000_0004;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        core_pc = '0;
        #3 rst = 1'b0;
        #1;
        check("por_rst_n", a_core_rst_n, 2'b00);
        check("por_status", {a_running, a_done, a_timeout, a_halted}, 5'b0);
        check("por_count", a_cycle_count, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("idle_state", a_state, ST_IDLE);
        check("idle_rst_n", b_core_rst_n, 2'b00);

        // Halt scenario, with a start pulse in RUN that must be ignored.
        do_hold();
        run_halt(1'b1);

        // Restart from DONE reapplies the hold and repeats the run exactly.
        do_hold();
        run_halt(1'b0);

        // Watchdog: PCs never repeat.
        do_hold();
        for (int k = 1; k <= 100; k++) begin
            core_pc = {32'h2000 + 32'(k * 4), 32'(k * 4)};
            check($sformatf("wd_c%0d_count_a", k), a_cycle_count, 32'(k));
            check($sformatf("wd_c%0d_timeout_a", k), a_timeout, 1'b0);
            check($sformatf("wd_c%0d_count_b", k), b_cycle_count, (k <= 29) ? 32'(k) : 32'd29);
            check($sformatf("wd_c%0d_timeout_b", k), b_timeout, k > 29);
            tick();
        end
        check("wd_timeout_a", a_timeout, 1'b1);
        check("wd_done_a", a_done, 1'b0);
        check("wd_count_a", a_cycle_count, 32'd100);
        check("wd_running_a", a_running, 1'b0);
        check("wd_halted_a", a_halted, 2'b00);
        check("wd_rst_n_a", a_core_rst_n, 2'b11);
        check("wd_state_a", a_state, ST_TIMEOUT);
        check("wd_done_b", b_done, 1'b0);

        // Asynchronous reset mid-RUN.
        do_hold();
        for (int k = 1; k <= 5; k++) begin
            core_pc = {32'd7, 32'(k * 8)};
            tick();
        end
        #2 rst = 1'b0;
        #1;
        check("arst_run_rst_n", a_core_rst_n, 2'b00);
        check("arst_run_status", {a_running, a_done, a_timeout, a_halted}, 5'b0);
        check("arst_run_count", a_cycle_count, 32'd0);
        check("arst_run_state", a_state, ST_IDLE);
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("arst_run_idle", a_state, ST_IDLE);
        check("arst_run_idle_rst_n", a_core_rst_n, 2'b00);

        // Asynchronous reset mid-HOLD: no RUN follows.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("arst_hold_entered", a_state, ST_HOLD);
        #2 rst = 1'b0;
        #1;
        check("arst_hold_state", a_state, ST_IDLE);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("arst_hold_stay_idle", a_state, ST_IDLE);
            check("arst_hold_rst_n", a_core_rst_n, 2'b00);
            check("arst_hold_running", a_running, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
